// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types and default sizing for the in-order issue queue.
// The queue element is a decoded micro-op as handed over by decode.
package issue_queue_ctrl_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int IQ_PUSH_W = 4;
  localparam int IQ_POP_W  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  uop;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
  } issue_queue_element_t;

endpackage

// File: rtl/iq_ptr_calc.sv
// Combinational index generation for the issue queue.
// Produces wrapped RAM write indices for each push slot and read indices for each issue port.
module iq_ptr_calc #(
  parameter  int DEPTH  = 16,
  parameter  int PUSH_W = 4,
  parameter  int POP_W  = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic [AW-1:0]             head_idx,
  input  logic [AW-1:0]             tail_idx,
  output logic [PUSH_W-1:0][AW-1:0] wr_idx,
  output logic [POP_W-1:0][AW-1:0]  rd_idx
);

  // DEPTH is a power of two, so dropping the carry out of AW bits is the modulo.
  always_comb begin
    for (int k = 0; k < PUSH_W; k++) begin
      wr_idx[k] = tail_idx + AW'(k);
    end
    for (int i = 0; i < POP_W; i++) begin
      rd_idx[i] = head_idx + AW'(i);
    end
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// In-order issue queue between decode and the issue ports.
// Up to PUSH_W writes and POP_W oldest-first reads per cycle; flush empties the queue.
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PUSH_W = IQ_PUSH_W,
  parameter int POP_W  = IQ_POP_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  issue_queue_element_t [PUSH_W-1:0] push_element,
  input  logic [2:0]                        issue_queue_push_number,
  output logic [2:0]                        iq_size_left,
  input  logic                              flush,
  output issue_queue_element_t [POP_W-1:0]  issue_element,
  output logic [POP_W-1:0]                  issue_valid,
  input  logic [POP_W-1:0]                  issue_ready,
  output logic                              empty,
  output logic                              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
  localparam logic [PW-1:0] PUSH_MAX   = PW'(PUSH_W);
  localparam logic [PW-1:0] SIZE_LEFT_SAT = PW'(7);

  issue_queue_element_t ram [DEPTH];

  logic [PW-1:0] head, tail, count;
  logic [PW-1:0] free_slots, push_req, push_n, pop_n;
  logic          push_ok;
  logic [POP_W-1:0] pop_vec;

  logic [PUSH_W-1:0][AW-1:0] wr_idx;
  logic [POP_W-1:0][AW-1:0]  rd_idx;

  iq_ptr_calc #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W)
  ) u_ptr_calc (
    .head_idx (head[AW-1:0]),
    .tail_idx (tail[AW-1:0]),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx)
  );

  // Capacity is judged on the registered count only; same-cycle pops earn no credit.
  always_comb begin
    free_slots = DEPTH_P - count;
    push_req   = PW'(issue_queue_push_number);
    if (push_req > PUSH_MAX) begin
      push_req = '0;
    end
    push_ok = (push_req <= free_slots);
    push_n  = push_ok ? push_req : '0;
  end

  // Port i may only issue when every older port issues in the same cycle.
  always_comb begin
    issue_valid = '0;
    pop_vec     = '0;
    pop_n       = '0;
    for (int i = 0; i < POP_W; i++) begin
      issue_valid[i]   = (count > PW'(i));
      issue_element[i] = ram[rd_idx[i]];
    end
    pop_vec[0] = issue_valid[0] & issue_ready[0];
    for (int i = 1; i < POP_W; i++) begin
      pop_vec[i] = pop_vec[i-1] & issue_valid[i] & issue_ready[i];
    end
    for (int i = 0; i < POP_W; i++) begin
      pop_n = pop_n + PW'(pop_vec[i]);
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_P);
  assign iq_size_left = (free_slots > SIZE_LEFT_SAT) ? 3'd7 : free_slots[2:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n;
      tail  <= tail + push_n;
      count <= count + push_n - pop_n;
    end
  end

  // NOTE: the entry RAM is not reset; occupancy is tracked by count, so stale contents are never visible as valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (PW'(k) < push_n) begin
          ram[wr_idx[k]] <= push_element[k];
        end
      end
    end
  end

endmodule
